// File: rtl/frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// frame_scheduler_if
//   Bundles the control, handshake and result signals of frame_scheduler.
//   The scheduler connects through the master modport; the pipeline/host
//   side (colour processor, centroid calculator, result consumer) uses slave.
//
//   Signals (direction as seen by the master):
//     enable           in   run the scan continuously
//     filter_mask      in   filters to scan, [2]=R [1]=G [0]=B
//     frame_start      in   1-cycle frame boundary pulse
//     centroid_valid   in   1-cycle pulse, centroid_in valid
//     centroid_in      in   centroid column of the just-finished frame
//     src_sel          out  selected image source
//     rgbfilter        out  one-hot filter to the colour processor
//     busy             out  scheduler not idle
//     result_valid     out  1-cycle pulse, result_* valid
//     result_src       out  source of the result
//     result_filter    out  one-hot filter of the result
//     result_centroid  out  centroid, all ones on timeout
//     result_timeout   out  result produced by the watchdog
//     round_cnt        out  completed full rounds (wraps)
// ----------------------------------------------------------------------------
interface frame_scheduler_if #(
    parameter int SRC_W  = 1,
    parameter int CENT_W = 7
);
    logic              enable;
    logic [2:0]        filter_mask;
    logic              frame_start;
    logic              centroid_valid;
    logic [CENT_W-1:0] centroid_in;

    logic [SRC_W-1:0]  src_sel;
    logic [2:0]        rgbfilter;
    logic              busy;
    logic              result_valid;
    logic [SRC_W-1:0]  result_src;
    logic [2:0]        result_filter;
    logic [CENT_W-1:0] result_centroid;
    logic              result_timeout;
    logic [7:0]        round_cnt;

    modport master (
        input  enable, filter_mask, frame_start, centroid_valid, centroid_in,
        output src_sel, rgbfilter, busy, result_valid, result_src,
               result_filter, result_centroid, result_timeout, round_cnt
    );

    modport slave (
        output enable, filter_mask, frame_start, centroid_valid, centroid_in,
        input  src_sel, rgbfilter, busy, result_valid, result_src,
               result_filter, result_centroid, result_timeout, round_cnt
    );
endinterface

// File: rtl/frame_scheduler.sv
// ----------------------------------------------------------------------------
// frame_scheduler
//   Steps the colour-centroid pipeline through every (source, filter) pair.
//   For each pair it drives src_sel/rgbfilter, waits for the next frame
//   boundary so the pipeline is clean under the new configuration, then
//   captures the first centroid that follows and reports it tagged with its
//   source and filter. A per-slot watchdog guarantees forward progress when
//   the pipeline never delivers a centroid.
//
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  asynchronous active-high reset
//     bus   master side of frame_scheduler_if (controls, handshake, results)
//
//   Scan order per round: src 0..NUM_SRC-1, and within each source
//   R(100) -> G(010) -> B(001), skipping filters whose mask bit is clear.
//   The filter mask is sampled only when a round starts.
// ----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int NUM_SRC = 2,
    parameter int SRC_W   = 1,
    parameter int CENT_W  = 7,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              rst,
    frame_scheduler_if.master bus
);

    localparam logic [SRC_W-1:0]  SRC_LAST      = SRC_W'(NUM_SRC - 1);
    localparam logic [TO_W-1:0]   WD_LIMIT      = TO_W'(TIMEOUT - 1);
    localparam logic [CENT_W-1:0] CENT_ALL_ONES = {CENT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    // Highest-priority set bit in R,G,B order; 000 when the mask is empty.
    function automatic logic [2:0] first_filter(input logic [2:0] mask);
        logic [2:0] res;
        if (mask[2]) begin
            res = 3'b100;
        end else if (mask[1]) begin
            res = 3'b010;
        end else if (mask[0]) begin
            res = 3'b001;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Next enabled filter strictly after cur (one-hot) in R,G,B order.
    // cur - 1 turns a one-hot value into a mask of all later filters.
    function automatic logic [2:0] filter_after(input logic [2:0] mask,
                                                input logic [2:0] cur);
        return first_filter(mask & (cur - 3'd1));
    endfunction

    state_t            state_q;
    logic [2:0]        mask_q;
    logic [TO_W-1:0]   wd_q;
    logic [SRC_W-1:0]  src_sel_q;
    logic [2:0]        rgbfilter_q;
    logic              busy_q;
    logic              result_valid_q;
    logic [SRC_W-1:0]  result_src_q;
    logic [2:0]        result_filter_q;
    logic [CENT_W-1:0] result_centroid_q;
    logic              result_timeout_q;
    logic [7:0]        round_cnt_q;

    logic [2:0]        start_filter_s;
    logic [2:0]        after_cur_s;
    logic [2:0]        adv_filter_s;
    logic [SRC_W-1:0]  adv_src_s;
    logic              round_end_s;
    logic              wd_expired_s;

    // Next-configuration lookahead used by IDLE (round start) and NEXT.
    always_comb begin
        start_filter_s = first_filter(bus.filter_mask);
        after_cur_s    = filter_after(mask_q, rgbfilter_q);
        wd_expired_s   = (wd_q == WD_LIMIT);
        adv_filter_s   = after_cur_s;
        adv_src_s      = src_sel_q;
        round_end_s    = 1'b0;
        if (after_cur_s != 3'b000) begin
            // Another filter remains for this source.
            adv_filter_s = after_cur_s;
            adv_src_s    = src_sel_q;
            round_end_s  = 1'b0;
        end else if (src_sel_q != SRC_LAST) begin
            // Filters exhausted: move to the next source, restart filters.
            adv_filter_s = first_filter(mask_q);
            adv_src_s    = src_sel_q + SRC_W'(1);
            round_end_s  = 1'b0;
        end else begin
            // Last source done: new round with a freshly sampled mask.
            adv_filter_s = start_filter_s;
            adv_src_s    = '0;
            round_end_s  = 1'b1;
        end
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            mask_q            <= 3'b000;
            wd_q              <= '0;
            src_sel_q         <= '0;
            rgbfilter_q       <= 3'b000;
            busy_q            <= 1'b0;
            result_valid_q    <= 1'b0;
            result_src_q      <= '0;
            result_filter_q   <= 3'b000;
            result_centroid_q <= '0;
            result_timeout_q  <= 1'b0;
            round_cnt_q       <= 8'd0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable && (bus.filter_mask != 3'b000)) begin
                        mask_q      <= bus.filter_mask;
                        src_sel_q   <= '0;
                        rgbfilter_q <= start_filter_s;
                        wd_q        <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ARM;
                    end else begin
                        rgbfilter_q <= 3'b000;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                // Waiting for a frame boundary; any centroid now belongs to
                // the previous configuration and is dropped.
                ST_ARM: begin
                    if (wd_expired_s) begin
                        result_valid_q    <= 1'b1;
                        result_src_q      <= src_sel_q;
                        result_filter_q   <= rgbfilter_q;
                        result_centroid_q <= CENT_ALL_ONES;
                        result_timeout_q  <= 1'b1;
                        state_q           <= ST_CAPTURE;
                    end else if (bus.frame_start) begin
                        wd_q    <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        wd_q    <= wd_q + TO_W'(1);
                        state_q <= ST_ARM;
                    end
                end

                // Clean frame in flight; the first centroid is ours. Further
                // frame boundaries are ignored.
                ST_RUN: begin
                    if (bus.centroid_valid) begin
                        result_valid_q    <= 1'b1;
                        result_src_q      <= src_sel_q;
                        result_filter_q   <= rgbfilter_q;
                        result_centroid_q <= bus.centroid_in;
                        result_timeout_q  <= 1'b0;
                        state_q           <= ST_CAPTURE;
                    end else if (wd_expired_s) begin
                        result_valid_q    <= 1'b1;
                        result_src_q      <= src_sel_q;
                        result_filter_q   <= rgbfilter_q;
                        result_centroid_q <= CENT_ALL_ONES;
                        result_timeout_q  <= 1'b1;
                        state_q           <= ST_CAPTURE;
                    end else begin
                        wd_q    <= wd_q + TO_W'(1);
                        state_q <= ST_RUN;
                    end
                end

                // result_valid is high for exactly this cycle.
                ST_CAPTURE: begin
                    wd_q    <= '0;
                    state_q <= ST_NEXT;
                end

                ST_NEXT: begin
                    if (round_end_s) begin
                        round_cnt_q <= round_cnt_q + 8'd1;
                        mask_q      <= bus.filter_mask;
                    end else begin
                        mask_q      <= mask_q;
                    end
                    wd_q <= '0;
                    if (!bus.enable) begin
                        // Source is left where it was; filter parked.
                        rgbfilter_q <= 3'b000;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (adv_filter_s == 3'b000) begin
                        // New round sampled an empty mask.
                        src_sel_q   <= adv_src_s;
                        rgbfilter_q <= 3'b000;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        src_sel_q   <= adv_src_s;
                        rgbfilter_q <= adv_filter_s;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ARM;
                    end
                end

                default: begin
                    rgbfilter_q <= 3'b000;
                    busy_q      <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.src_sel         = src_sel_q;
    assign bus.rgbfilter       = rgbfilter_q;
    assign bus.busy            = busy_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.result_src      = result_src_q;
    assign bus.result_filter   = result_filter_q;
    assign bus.result_centroid = result_centroid_q;
    assign bus.result_timeout  = result_timeout_q;
    assign bus.round_cnt       = round_cnt_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_frame_scheduler
//   Directed bench for frame_scheduler. dut_a (long watchdog) covers the scan
//   order, mask sampling, stale/tied centroids, enable drop and reset;
//   dut_b (TIMEOUT=50) covers the watchdog path.
// ----------------------------------------------------------------------------
module tb_frame_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    frame_scheduler_if #(.SRC_W(1), .CENT_W(7)) ifa ();
    frame_scheduler_if #(.SRC_W(1), .CENT_W(7)) ifb ();

    frame_scheduler #(
        .NUM_SRC(2), .SRC_W(1), .CENT_W(7), .TO_W(16), .TIMEOUT(400)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    frame_scheduler #(
        .NUM_SRC(2), .SRC_W(1), .CENT_W(7), .TO_W(16), .TIMEOUT(50)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ordinary slot on dut_a: frame boundary, 100 cycles, centroid.
    task automatic slot(input string tag, input logic [6:0] cent,
                        input logic [0:0] esrc, input logic [2:0] efilt);
        chk({tag, ".src_sel"},   32'(ifa.src_sel),   32'(esrc));
        chk({tag, ".rgbfilter"}, 32'(ifa.rgbfilter), 32'(efilt));
        ifa.frame_start = 1'b1;
        tick();
        ifa.frame_start = 1'b0;
        repeat (100) tick();
        ifa.centroid_valid = 1'b1;
        ifa.centroid_in    = cent;
        tick();
        ifa.centroid_valid = 1'b0;
        chk({tag, ".rv"},    32'(ifa.result_valid),    32'd1);
        chk({tag, ".rsrc"},  32'(ifa.result_src),      32'(esrc));
        chk({tag, ".rfilt"}, 32'(ifa.result_filter),   32'(efilt));
        chk({tag, ".rcent"}, 32'(ifa.result_centroid), 32'(cent));
        chk({tag, ".rto"},   32'(ifa.result_timeout),  32'd0);
        tick();
        chk({tag, ".rv_pulse"}, 32'(ifa.result_valid), 32'd0);
        tick();
    endtask

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ifa.enable = 1'b0; ifa.filter_mask = 3'b000; ifa.frame_start = 1'b0;
        ifa.centroid_valid = 1'b0; ifa.centroid_in = 7'd0;
        ifb.enable = 1'b0; ifb.filter_mask = 3'b000; ifb.frame_start = 1'b0;
        ifb.centroid_valid = 1'b0; ifb.centroid_in = 7'd0;

        repeat (3) tick();
        chk("rst.busy",  32'(ifa.busy),      32'd0);
        chk("rst.filt",  32'(ifa.rgbfilter), 32'd0);
        chk("rst.src",   32'(ifa.src_sel),   32'd0);
        chk("rst.rv",    32'(ifa.result_valid), 32'd0);
        chk("rst.round", 32'(ifa.round_cnt), 32'd0);

        // Full scan, mask 111.
        rst = 1'b0;
        ifa.enable = 1'b1;
        ifa.filter_mask = 3'b111;
        tick();
        chk("start.busy", 32'(ifa.busy), 32'd1);
        slot("r1s0R", 7'd10, 1'b0, 3'b100);
        slot("r1s0G", 7'd20, 1'b0, 3'b010);
        slot("r1s0B", 7'd30, 1'b0, 3'b001);
        slot("r1s1R", 7'd40, 1'b1, 3'b100);
        slot("r1s1G", 7'd50, 1'b1, 3'b010);
        ifa.filter_mask = 3'b101;
        chk("r1.round_before", 32'(ifa.round_cnt), 32'd0);
        slot("r1s1B", 7'd60, 1'b1, 3'b001);
        chk("r1.round", 32'(ifa.round_cnt), 32'd1);

        // Mask 101 round; mask change mid-round waits for the wrap.
        slot("r2s0R", 7'd11, 1'b0, 3'b100);
        ifa.filter_mask = 3'b010;
        slot("r2s0B", 7'd12, 1'b0, 3'b001);
        slot("r2s1R", 7'd13, 1'b1, 3'b100);
        slot("r2s1B", 7'd14, 1'b1, 3'b001);
        chk("r2.round", 32'(ifa.round_cnt), 32'd2);

        // Stale centroid in ARM, lone frame_start in RUN, tie in RUN.
        chk("r3s0.src",  32'(ifa.src_sel),   32'd0);
        chk("r3s0.filt", 32'(ifa.rgbfilter), 32'b010);
        ifa.centroid_valid = 1'b1;
        ifa.centroid_in    = 7'd99;
        tick();
        ifa.centroid_valid = 1'b0;
        chk("stale.rv0", 32'(ifa.result_valid), 32'd0);
        tick();
        chk("stale.rv1", 32'(ifa.result_valid), 32'd0);
        ifa.frame_start = 1'b1;
        tick();
        ifa.frame_start = 1'b0;
        repeat (5) tick();
        ifa.frame_start = 1'b1;
        tick();
        ifa.frame_start = 1'b0;
        chk("lone_fs.rv", 32'(ifa.result_valid), 32'd0);
        repeat (5) tick();
        ifa.frame_start    = 1'b1;
        ifa.centroid_valid = 1'b1;
        ifa.centroid_in    = 7'd77;
        tick();
        ifa.frame_start    = 1'b0;
        ifa.centroid_valid = 1'b0;
        chk("tie.rv",    32'(ifa.result_valid),    32'd1);
        chk("tie.rcent", 32'(ifa.result_centroid), 32'd77);
        chk("tie.rfilt", 32'(ifa.result_filter),   32'b010);
        chk("tie.rsrc",  32'(ifa.result_src),      32'd0);
        tick();
        tick();
        chk("r3s1.src",  32'(ifa.src_sel),   32'd1);
        chk("r3s1.filt", 32'(ifa.rgbfilter), 32'b010);

        // Enable dropped during RUN: slot completes, then IDLE.
        ifa.frame_start = 1'b1;
        tick();
        ifa.frame_start = 1'b0;
        repeat (5) tick();
        ifa.enable = 1'b0;
        repeat (5) tick();
        chk("endrop.busy_run", 32'(ifa.busy), 32'd1);
        ifa.centroid_valid = 1'b1;
        ifa.centroid_in    = 7'd55;
        tick();
        ifa.centroid_valid = 1'b0;
        chk("endrop.rv",    32'(ifa.result_valid),    32'd1);
        chk("endrop.rcent", 32'(ifa.result_centroid), 32'd55);
        tick();
        tick();
        chk("endrop.filt", 32'(ifa.rgbfilter), 32'd0);
        chk("endrop.busy", 32'(ifa.busy),      32'd0);

        // Empty mask with enable set keeps the scheduler idle.
        ifa.filter_mask = 3'b000;
        ifa.enable      = 1'b1;
        repeat (5) tick();
        chk("mask0.busy", 32'(ifa.busy),      32'd0);
        chk("mask0.filt", 32'(ifa.rgbfilter), 32'd0);

        // Watchdog on dut_b: no centroid ever arrives.
        ifb.enable      = 1'b1;
        ifb.filter_mask = 3'b100;
        tick();
        chk("wd.busy", 32'(ifb.busy), 32'd1);
        n = 0;
        while ((ifb.result_valid !== 1'b1) && (n < 200)) begin
            tick();
            n = n + 1;
        end
        chk("wd.cycles", 32'(n),                   32'd50);
        chk("wd.rto",    32'(ifb.result_timeout),  32'd1);
        chk("wd.rcent",  32'(ifb.result_centroid), 32'h7F);
        chk("wd.rsrc",   32'(ifb.result_src),      32'd0);
        chk("wd.rfilt",  32'(ifb.result_filter),   32'b100);
        tick();
        chk("wd.rv_pulse", 32'(ifb.result_valid), 32'd0);
        tick();
        chk("wd.next_src",  32'(ifb.src_sel),   32'd1);
        chk("wd.next_filt", 32'(ifb.rgbfilter), 32'b100);
        chk("wd.next_busy", 32'(ifb.busy),      32'd1);

        // Reset mid-RUN on dut_a, then restart.
        ifa.filter_mask = 3'b111;
        tick();
        ifa.frame_start = 1'b1;
        tick();
        ifa.frame_start = 1'b0;
        repeat (5) tick();
        chk("prerst.busy", 32'(ifa.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst.busy",  32'(ifa.busy),         32'd0);
        chk("arst.filt",  32'(ifa.rgbfilter),    32'd0);
        chk("arst.src",   32'(ifa.src_sel),      32'd0);
        chk("arst.rv",    32'(ifa.result_valid), 32'd0);
        chk("arst.round", 32'(ifa.round_cnt),    32'd0);
        chk("arst.b_busy", 32'(ifb.busy),        32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("restart.src",  32'(ifa.src_sel),   32'd0);
        chk("restart.filt", 32'(ifa.rgbfilter), 32'b100);
        chk("restart.busy", 32'(ifa.busy),      32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
